// File: rtl/riscv_alu_mdu.sv
// riscv_alu_mdu: RV32I/RV64I base ALU plus RV32M/RV64M multiply/divide as one
// handshaked execution unit. Base ops and M-extension corner cases finish in one
// cycle; MUL* run either as one wide product or as a shift-add loop; DIV*/REM*
// run a restoring divider producing one quotient bit per cycle.
module riscv_alu_mdu #(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            lt_signed_o,
    output logic            lt_unsigned_o
);

    localparam int SHW  = $clog2(XLEN);
    localparam int CW   = $clog2(XLEN) + 1;
    localparam bit FAST = (FAST_MUL != 0);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_PASSA  = 5'd10;
    localparam logic [4:0] OP_PASSB  = 5'd11;
    localparam logic [4:0] OP_MUL    = 5'd12;
    localparam logic [4:0] OP_MULH   = 5'd13;
    localparam logic [4:0] OP_MULHSU = 5'd14;
    localparam logic [4:0] OP_MULHU  = 5'd15;
    localparam logic [4:0] OP_DIV    = 5'd16;
    localparam logic [4:0] OP_DIVU   = 5'd17;
    localparam logic [4:0] OP_REM    = 5'd18;
    localparam logic [4:0] OP_REMU   = 5'd19;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4:0]          op_q, op_d;
    logic [XLEN-1:0]     a_mag_q, a_mag_d;
    logic [XLEN-1:0]     b_mag_q, b_mag_d;
    logic                neg_q, neg_d;      // sign of product / quotient
    logic                rneg_q, rneg_d;    // sign of remainder (dividend sign)
    logic [2*XLEN-1:0]   p_q, p_d;          // product accumulator or {remainder, quotient}
    logic [XLEN-1:0]     result_q, result_d;
    logic                lts_q, lts_d;
    logic                ltu_q, ltu_d;

    // Base ALU result; anything outside 0-11 yields zero.
    function automatic logic [XLEN-1:0] alu_base(input logic [4:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [SHW-1:0] shamt;
        logic [XLEN-1:0] r;
        shamt = b[SHW-1:0];
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_SLL:   r = a << shamt;
            OP_SRL:   r = a >> shamt;
            OP_SRA:   r = $signed(a) >>> shamt;
            OP_SLT:   r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  r = {{(XLEN-1){1'b0}}, (a < b)};
            OP_PASSA: r = a;
            OP_PASSB: r = b;
            default:  r = {XLEN{1'b0}};
        endcase
        return r;
    endfunction

    // Apply the deferred sign and pick the architectural half of the raw result.
    function automatic logic [XLEN-1:0] mdu_finish(input logic [4:0] op,
                                                   input logic neg,
                                                   input logic rneg,
                                                   input logic [2*XLEN-1:0] p);
        logic [2*XLEN-1:0] prod_s;
        logic [XLEN-1:0]   quo_s;
        logic [XLEN-1:0]   rem_s;
        logic [XLEN-1:0]   r;
        prod_s = neg  ? -p : p;
        quo_s  = neg  ? -p[XLEN-1:0]      : p[XLEN-1:0];
        rem_s  = rneg ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
        case (op)
            OP_MUL:                         r = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   r = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                r = quo_s;
            OP_REM, OP_REMU:                r = rem_s;
            default:                        r = {XLEN{1'b0}};
        endcase
        return r;
    endfunction

    // Operand decode at accept time.
    logic            is_mul_s, is_div_s, is_mdu_s, sgn_a_s, sgn_b_s;
    logic            a_neg_s, b_neg_s, b_zero_s, ovf_s;
    logic [XLEN-1:0] a_abs_s, b_abs_s;

    // Classify the incoming op and form operand magnitudes.
    always_comb begin
        is_mul_s = (alu_op_i >= OP_MUL) && (alu_op_i <= OP_MULHU);
        is_div_s = (alu_op_i >= OP_DIV) && (alu_op_i <= OP_REMU);
        is_mdu_s = is_mul_s || is_div_s;
        sgn_a_s  = (alu_op_i == OP_MUL) || (alu_op_i == OP_MULH) || (alu_op_i == OP_MULHSU)
                || (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
        sgn_b_s  = (alu_op_i == OP_MUL) || (alu_op_i == OP_MULH)
                || (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
        a_neg_s  = sgn_a_s && operand_a_i[XLEN-1];
        b_neg_s  = sgn_b_s && operand_b_i[XLEN-1];
        a_abs_s  = a_neg_s ? -operand_a_i : operand_a_i;
        b_abs_s  = b_neg_s ? -operand_b_i : operand_b_i;
        b_zero_s = (operand_b_i == {XLEN{1'b0}});
        ovf_s    = ((alu_op_i == OP_DIV) || (alu_op_i == OP_REM))
                && (operand_a_i == {1'b1, {(XLEN-1){1'b0}}})
                && (operand_b_i == {XLEN{1'b1}});
    end

    // One iteration of the multi-cycle datapaths.
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN-1:0]   div_diff_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] fast_prod_s;
    logic [2*XLEN-1:0] p_next_s;

    // Shift-add step, restoring-divide step and single-cycle product.
    always_comb begin
        mul_sum_s   = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, (p_q[0] ? a_mag_q : {XLEN{1'b0}})};
        div_shift_s = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_mag_q});
        // Remainder stays below the divisor, so modular XLEN-bit subtraction is exact.
        div_diff_s  = div_shift_s[XLEN-1:0] - b_mag_q;
        fast_prod_s = {{XLEN{1'b0}}, a_mag_q} * {{XLEN{1'b0}}, b_mag_q};
        if (op_q >= OP_DIV) begin
            p_next_s = {(div_ge_s ? div_diff_s : div_shift_s[XLEN-1:0]),
                        p_q[XLEN-2:0], div_ge_s};
        end else if (FAST) begin
            p_next_s = fast_prod_s;
        end else begin
            p_next_s = {mul_sum_s, p_q[XLEN-1:1]};
        end
    end

    // Next-state logic: accept, iterate, hand off, flush.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        p_d      = p_q;
        result_d = result_q;
        lts_d    = lts_q;
        ltu_d    = ltu_q;
        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (valid_i) begin
                    op_d    = alu_op_i;
                    lts_d   = ($signed(operand_a_i) < $signed(operand_b_i));
                    ltu_d   = (operand_a_i < operand_b_i);
                    a_mag_d = a_abs_s;
                    b_mag_d = b_abs_s;
                    neg_d   = a_neg_s ^ b_neg_s;
                    rneg_d  = a_neg_s;
                    if (!is_mdu_s) begin
                        result_d = alu_base(alu_op_i, operand_a_i, operand_b_i);
                        state_d  = S_DONE;
                    end else if (is_div_s && b_zero_s) begin
                        result_d = ((alu_op_i == OP_DIV) || (alu_op_i == OP_DIVU))
                                   ? {XLEN{1'b1}} : operand_a_i;
                        state_d  = S_DONE;
                    end else if (ovf_s) begin
                        result_d = (alu_op_i == OP_DIV) ? operand_a_i : {XLEN{1'b0}};
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = (is_mul_s && FAST) ? CW'(1) : CW'(XLEN);
                        p_d     = {{XLEN{1'b0}}, (is_mul_s ? b_abs_s : a_abs_s)};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    p_d   = p_next_s;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_d = mdu_finish(op_q, neg_q, rneg_q, p_next_s);
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_DONE: begin
                if (flush_i || ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            op_q     <= 5'd0;
            a_mag_q  <= {XLEN{1'b0}};
            b_mag_q  <= {XLEN{1'b0}};
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            p_q      <= {(2*XLEN){1'b0}};
            result_q <= {XLEN{1'b0}};
            lts_q    <= 1'b0;
            ltu_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            p_q      <= p_d;
            result_q <= result_d;
            lts_q    <= lts_d;
            ltu_q    <= ltu_d;
        end
    end

    assign ready_o       = (state_q == S_IDLE);
    assign valid_o       = (state_q == S_DONE);
    assign result_o      = result_q;
    assign zero_o        = (result_q == {XLEN{1'b0}});
    assign lt_signed_o   = lts_q;
    assign lt_unsigned_o = ltu_q;

endmodule
